// File: rtl/pulse_reg_pkg.sv
// pulse_reg_pkg -- shared constants for the multi-channel pulse toggle block.
//   MODE_SHARED / MODE_PER_CH : encodings for the MODE parameter of multi_pulse_toggle
//   SYNC_DEPTH                : flop count of the optional input synchroniser
//   deb_cnt_w()               : width of a debounce stability counter for a given window
package pulse_reg_pkg;

  localparam int MODE_SHARED = 0;
  localparam int MODE_PER_CH = 1;
  localparam int SYNC_DEPTH  = 2;

  // The counter only needs to reach window-1, but is never narrower than one bit.
  function automatic int deb_cnt_w(input int window);
    if (window <= 1) begin
      return 1;
    end else begin
      return $clog2(window);
    end
  endfunction

endpackage

// File: rtl/pulse_deb_edge.sv
// pulse_deb_edge -- one channel of conditioning: optional synchroniser, input
// sample register, debouncer and rising-edge detector.
// Build option: PULSE_SYNC_EN inserts a SYNC_DEPTH-flop synchroniser ahead of
// the sample register.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   in_i   : raw input level
//   rise_o : combinational 0->1 indication of the debounced level (the parent
//            registers it, so it is high for exactly one cycle per rise)
module pulse_deb_edge
  import pulse_reg_pkg::*;
#(
  parameter int DEB_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_i,
  output logic rise_o
);

  logic w_raw;
  logic r_samp;
  logic w_level;
  logic r_level_d;

`ifdef PULSE_SYNC_EN
  logic [SYNC_DEPTH-1:0] r_sync;

  // Two-flop synchroniser for asynchronous button/pulse inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], in_i};
    end
  end

  assign w_raw = r_sync[SYNC_DEPTH-1];
`else
  assign w_raw = in_i;
`endif

  // Sample register: the single point where the (synchronised) input is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_samp <= 1'b0;
    end else begin
      r_samp <= w_raw;
    end
  end

  generate
    if (DEB_CYCLES == 0) begin : g_bypass
      assign w_level = r_samp;
    end else begin : g_deb
      localparam int CW = deb_cnt_w(DEB_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

      logic [CW-1:0] r_cnt;
      logic          r_deb;

      // The level is one bit, so the candidate is always the complement of the
      // debounced level; the counter measures how long the sample has held it.
      // Any cycle where the sample matches the level again restarts the count.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
          r_deb <= 1'b0;
        end else if (r_samp != r_deb) begin
          if (r_cnt == LAST) begin
            r_deb <= r_samp;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_level = r_deb;
    end
  endgenerate

  // Previous debounced level, for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= w_level;
    end
  end

  assign rise_o = w_level & ~r_level_d;

endmodule

// File: rtl/multi_pulse_toggle.sv
// multi_pulse_toggle -- N_CH debounced pulse inputs driving toggle state bits.
// Build option: PULSE_SYNC_EN adds a 2-flop synchroniser per channel (+2 cycles).
// Parameters: N_CH channels, MODE (MODE_SHARED: one common toggle, MODE_PER_CH:
// one toggle per channel), DEB_CYCLES debounce window (0 = bypass), CNT_W event
// counter width, INIT_STATE reset value of every state bit.
// Ports:
//   clk, rst    : clock (rising edge) and synchronous active-high reset
//   in_i        : raw inputs, one per channel
//   edge_o      : registered one-cycle rising-edge pulses
//   state_o     : registered toggle state
//   any_edge_o  : registered OR of edge_o
//   evt_cnt_o   : wrapping count of cycles with any_edge_o high
module multi_pulse_toggle
  import pulse_reg_pkg::*;
#(
  parameter int   N_CH       = 2,
  parameter int   MODE       = 0,
  parameter int   DEB_CYCLES = 0,
  parameter int   CNT_W      = 8,
  parameter logic INIT_STATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in_i,
  output logic [N_CH-1:0]  edge_o,
  output logic [N_CH-1:0]  state_o,
  output logic             any_edge_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  logic [N_CH-1:0]  w_rise;
  logic             w_any;
  logic [N_CH-1:0]  w_toggle;
  logic [N_CH-1:0]  r_edge;
  logic [N_CH-1:0]  r_state;
  logic             r_any;
  logic [CNT_W-1:0] r_cnt;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      pulse_deb_edge #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_ch (
        .clk    (clk),
        .rst    (rst),
        .in_i   (in_i[gi]),
        .rise_o (w_rise[gi])
      );
    end
  endgenerate

  // Toggle mask: shared mode collapses simultaneous edges into one inversion.
  always_comb begin
    w_any    = |w_rise;
    w_toggle = '0;
    case (MODE)
      MODE_PER_CH: w_toggle = w_rise;
      MODE_SHARED: w_toggle = {N_CH{w_any}};
      default:     w_toggle = {N_CH{w_any}};
    endcase
  end

  // All outputs update together on the same edge; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge  <= '0;
      r_any   <= 1'b0;
      r_state <= {N_CH{INIT_STATE}};
      r_cnt   <= '0;
    end else begin
      r_edge  <= w_rise;
      r_any   <= w_any;
      r_state <= r_state ^ w_toggle;
      if (w_any) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  assign edge_o     = r_edge;
  assign state_o    = r_state;
  assign any_edge_o = r_any;
  assign evt_cnt_o  = r_cnt;

endmodule
